cart_entry_controller: RTL and testbench

Consumes the single-cycle KEY_En/CMD_En pulses produced by the button front end and turns them into a sale cart. The cart holds four per-product quantity counters, supports remove, clear and checkout commands, and clears itself on inactivity. On checkout it streams one record per non-zero product to the downstream sale/accounting logic over a valid/ready handshake.

---
 rtl/cart_pkg.sv | 43 ++++
 rtl/cart_qty_counter.sv | 35 +++
 rtl/cart_entry_controller.sv | 148 ++++++++++++++
 tb/tb_cart_entry_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and helpers for the sale-cart controller.
// Holds the FSM state type, command bit indices and the record scan function.
package cart_pkg;

   localparam int NUM_ITEMS    = 4;
   localparam int CMD_REMOVE   = 0;
   localparam int CMD_CLEAR    = 1;
   localparam int CMD_CHECKOUT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2
   } cart_state_e;

   typedef struct packed {
      logic       found;
      logic       last;
      logic [1:0] id;
   } scan_res_t;

   // Lowest non-zero product at or after start, plus whether it is the
   // final non-zero one. Works on a non-zero mask so it is width-agnostic.
   function automatic scan_res_t next_nonzero(
      input logic [NUM_ITEMS-1:0] nz,
      input logic [1:0]           start
   );
      scan_res_t r;
      r      = '0;
      r.last = 1'b1;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (!r.found && nz[i] && (i >= int'(start))) begin
            r.found = 1'b1;
            r.id    = 2'(i);
         end
      end
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (r.found && nz[i] && (i > int'(r.id))) r.last = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/cart_qty_counter.sv
// Saturating up/down quantity counter with synchronous clear.
// Ports: CLK, RST, inc, dec, clr (priority), q, at_max, at_zero.
module cart_qty_counter #(
   parameter int QTY_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [QTY_W-1:0] q,
   output logic             at_max,
   output logic             at_zero
);

   logic [QTY_W-1:0] q_q;
   logic [QTY_W-1:0] q_d;

   assign at_max  = &q_q;
   assign at_zero = ~|q_q;
   assign q       = q_q;

   always_comb begin
      q_d = q_q;
      if (clr)                        q_d = '0;
      else if (inc && !dec && !at_max) q_d = q_q + QTY_W'(1);
      else if (dec && !inc && !at_zero) q_d = q_q - QTY_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) q_q <= '0;
      else     q_q <= q_d;
   end

endmodule

// File: rtl/cart_entry_controller.sv
// Sale cart: per-product counters, remove/clear/checkout, idle timeout,
// checkout records streamed over ITEM_VALID/ITEM_READY. QTY_VIEW is live.
module cart_entry_controller
   import cart_pkg::*;
#(
   parameter int QTY_W          = 4,
   parameter int TIMEOUT_CYCLES = 1500000000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [3:0]             KEY_En,
   input  logic [3:0]             CMD_En,
   output logic                   ITEM_VALID,
   input  logic                   ITEM_READY,
   output logic [1:0]             ITEM_ID,
   output logic [QTY_W-1:0]       ITEM_QTY,
   output logic                   ITEM_LAST,
   output logic [4*QTY_W-1:0]     QTY_VIEW,
   output logic                   CART_EMPTY,
   output logic                   BUSY,
   output logic                   ERR,
   output logic                   TIMEOUT
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   cart_state_e      state_q, state_d;
   logic [1:0]       last_q, last_d;
   logic [1:0]       scan_q, scan_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             to_q, to_d;

   logic [NUM_ITEMS-1:0] inc, dec, clr;
   logic [NUM_ITEMS-1:0] at_max, at_zero, nz, nz_next;
   logic [QTY_W-1:0]     qty [NUM_ITEMS];
   logic                 activity;
   scan_res_t            rec;

   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_cnt
      cart_qty_counter #(.QTY_W(QTY_W)) u_cnt (
         .CLK     (CLK),
         .RST     (RST),
         .inc     (inc[g]),
         .dec     (dec[g]),
         .clr     (clr[g]),
         .q       (qty[g]),
         .at_max  (at_max[g]),
         .at_zero (at_zero[g])
      );
      assign nz[g] = ~at_zero[g];
      assign QTY_VIEW[g*QTY_W +: QTY_W] = qty[g];
   end

   assign rec      = next_nonzero(nz, scan_q);
   assign activity = (|KEY_En) | (|CMD_En);

   assign BUSY       = (state_q == SEND);
   assign ITEM_VALID = BUSY & rec.found;
   assign ITEM_ID    = ITEM_VALID ? rec.id : 2'd0;
   assign ITEM_QTY   = ITEM_VALID ? qty[rec.id] : '0;
   assign ITEM_LAST  = ITEM_VALID & rec.last;
   assign CART_EMPTY = ~|nz;
   assign ERR        = err_q;
   assign TIMEOUT    = to_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      scan_d  = scan_q;
      cnt_d   = '0;
      err_d   = 1'b0;
      to_d    = 1'b0;
      inc     = '0;
      dec     = '0;
      clr     = '0;
      nz_next = '0;
      unique case (state_q)
         SEND: begin
            // Sent entries are zeroed, so the scan never revisits them.
            if (ITEM_VALID && ITEM_READY) begin
               if (rec.last) begin
                  clr     = '1;
                  scan_d  = 2'd0;
                  state_d = IDLE;
               end else begin
                  clr[rec.id] = 1'b1;
                  scan_d      = rec.id + 2'd1;
               end
            end
         end
         default: begin
            if (CMD_En[CMD_CLEAR]) begin
               clr = '1;
            end else if (CMD_En[CMD_CHECKOUT]) begin
               if (CART_EMPTY) begin
                  err_d = 1'b1;
               end else begin
                  state_d = SEND;
                  scan_d  = 2'd0;
               end
            end else if (CMD_En[CMD_REMOVE]) begin
               if (at_zero[last_q]) err_d = 1'b1;
               else                 dec[last_q] = 1'b1;
            end else if (|KEY_En) begin
               inc   = KEY_En;
               err_d = |(KEY_En & at_max);
               for (int i = 0; i < NUM_ITEMS; i++) begin
                  if (KEY_En[i]) last_d = 2'(i);
               end
            end else if (state_q == FILL && cnt_q == CNT_LAST) begin
               clr  = '1;
               to_d = 1'b1;
            end
            if (state_d != SEND) begin
               for (int i = 0; i < NUM_ITEMS; i++) begin
                  nz_next[i] = inc[i] | (nz[i] & ~clr[i] &
                               ~(dec[i] & (qty[i] == QTY_W'(1))));
               end
               state_d = (|nz_next) ? FILL : IDLE;
            end
            // Idle count runs only while staying in FILL with no pulse.
            if (state_q == FILL && state_d == FILL && !activity)
               cnt_d = cnt_q + CNT_W'(1);
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         last_q  <= 2'd0;
         scan_q  <= 2'd0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         scan_q  <= scan_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_cart_entry_controller.sv
// Self-checking bench for cart_entry_controller.
// Checkout records are scoreboarded and compared on each handshake.
module tb_cart_entry_controller;

   localparam int QW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [3:0]    KEY_En = '0;
   logic [3:0]    CMD_En = '0;
   logic          ITEM_VALID;
   logic          ITEM_READY = 1'b0;
   logic [1:0]    ITEM_ID;
   logic [QW-1:0] ITEM_QTY;
   logic          ITEM_LAST;
   logic [4*QW-1:0] QTY_VIEW;
   logic          CART_EMPTY;
   logic          BUSY;
   logic          ERR;
   logic          TIMEOUT;

   typedef struct {
      logic [1:0]    id;
      logic [QW-1:0] qty;
      logic          last;
   } rec_t;

   rec_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_hs   = 0;

   cart_entry_controller #(
      .QTY_W          (QW),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .KEY_En     (KEY_En),
      .CMD_En     (CMD_En),
      .ITEM_VALID (ITEM_VALID),
      .ITEM_READY (ITEM_READY),
      .ITEM_ID    (ITEM_ID),
      .ITEM_QTY   (ITEM_QTY),
      .ITEM_LAST  (ITEM_LAST),
      .QTY_VIEW   (QTY_VIEW),
      .CART_EMPTY (CART_EMPTY),
      .BUSY       (BUSY),
      .ERR        (ERR),
      .TIMEOUT    (TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshake observed mid-cycle completes on the following edge.
   always @(negedge CLK) begin
      if (!RST && ITEM_VALID && ITEM_READY) begin
         n_hs++;
         if (sb.size() == 0) begin
            chk("sb_unexpected", 32'(ITEM_ID), 32'hFF);
         end else begin
            rec_t e;
            e = sb.pop_front();
            chk("rec_id", 32'(ITEM_ID), 32'(e.id));
            chk("rec_qty", 32'(ITEM_QTY), 32'(e.qty));
            chk("rec_last", 32'(ITEM_LAST), 32'(e.last));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic key(input logic [3:0] k);
      KEY_En = k;
      tick();
      KEY_En = '0;
   endtask

   task automatic cmd(input logic [3:0] c);
      CMD_En = c;
      tick();
      CMD_En = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic push(input logic [1:0] id, input logic [QW-1:0] q,
                       input logic l);
      rec_t r;
      r.id   = id;
      r.qty  = q;
      r.last = l;
      sb.push_back(r);
   endtask

   task automatic fill_std();
      key(4'b0010);
      key(4'b0010);
      key(4'b0010);
      key(4'b1000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]    sid;
      logic [QW-1:0] sq;
      logic          sl;
      int            hs0;
      int            cyc;
      logic          seen;

      tick();
      chk("rst_valid", 32'(ITEM_VALID), 0);
      chk("rst_id", 32'(ITEM_ID), 0);
      chk("rst_qty", 32'(ITEM_QTY), 0);
      chk("rst_last", 32'(ITEM_LAST), 0);
      chk("rst_view", 32'(QTY_VIEW), 0);
      chk("rst_empty", 32'(CART_EMPTY), 1);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_err", 32'(ERR), 0);
      chk("rst_to", 32'(TIMEOUT), 0);
      RST = 1'b0;

      // 1: streaming with ready held high
      fill_std();
      chk("t1_view", 32'(QTY_VIEW), 32'h1030);
      chk("t1_empty", 32'(CART_EMPTY), 0);
      push(2'd1, 4'd3, 1'b0);
      push(2'd3, 4'd1, 1'b1);
      ITEM_READY = 1'b1;
      cmd(4'b0100);
      chk("t1_valid_lat1", 32'(ITEM_VALID), 1);
      chk("t1_busy", 32'(BUSY), 1);
      tick();
      chk("t1_valid_2nd", 32'(ITEM_VALID), 1);
      chk("t1_id_2nd", 32'(ITEM_ID), 3);
      tick();
      chk("t1_valid_end", 32'(ITEM_VALID), 0);
      chk("t1_busy_end", 32'(BUSY), 0);
      chk("t1_empty_end", 32'(CART_EMPTY), 1);
      chk("t1_view_end", 32'(QTY_VIEW), 0);
      chk("t1_sb_drained", 32'(sb.size()), 0);
      ITEM_READY = 1'b0;

      // 2: stalled records, pulses ignored while sending
      fill_std();
      push(2'd1, 4'd3, 1'b0);
      push(2'd3, 4'd1, 1'b1);
      hs0 = n_hs;
      cmd(4'b0100);
      for (int r = 0; r < 2; r++) begin
         sid = ITEM_ID;
         sq  = ITEM_QTY;
         sl  = ITEM_LAST;
         chk("t2_valid", 32'(ITEM_VALID), 1);
         for (int i = 0; i < 5; i++) begin
            KEY_En = (i == 1) ? 4'b0001 : 4'b0000;
            CMD_En = (i == 3) ? 4'b0010 : 4'b0000;
            tick();
            KEY_En = '0;
            CMD_En = '0;
            chk("t2_stall_id", 32'(ITEM_ID), 32'(sid));
            chk("t2_stall_qty", 32'(ITEM_QTY), 32'(sq));
            chk("t2_stall_last", 32'(ITEM_LAST), 32'(sl));
            chk("t2_stall_err", 32'(ERR), 0);
         end
         ITEM_READY = 1'b1;
         tick();
         ITEM_READY = 1'b0;
      end
      chk("t2_handshakes", 32'(n_hs - hs0), 2);
      chk("t2_busy_end", 32'(BUSY), 0);
      chk("t2_view_end", 32'(QTY_VIEW), 0);
      chk("t2_sb_drained", 32'(sb.size()), 0);

      // 3: saturation and remove
      do_reset();
      for (int i = 0; i < 16; i++) begin
         key(4'b0001);
         chk("t3_sat_err", 32'(ERR), (i == 15) ? 1 : 0);
      end
      chk("t3_qty0", 32'(QTY_VIEW[3:0]), 15);
      do_reset();
      key(4'b0100);
      key(4'b0100);
      cmd(4'b0001);
      chk("t3_qty2_a", 32'(QTY_VIEW[11:8]), 1);
      chk("t3_rm_err_a", 32'(ERR), 0);
      cmd(4'b0001);
      chk("t3_qty2_b", 32'(QTY_VIEW[11:8]), 0);
      chk("t3_rm_err_b", 32'(ERR), 0);
      cmd(4'b0001);
      chk("t3_rm_err_c", 32'(ERR), 1);
      chk("t3_empty", 32'(CART_EMPTY), 1);

      // 4: checkout of an empty cart
      cmd(4'b0100);
      chk("t4_err", 32'(ERR), 1);
      chk("t4_valid", 32'(ITEM_VALID), 0);
      chk("t4_busy", 32'(BUSY), 0);
      tick();
      chk("t4_err_pulse", 32'(ERR), 0);
      chk("t4_busy_after", 32'(BUSY), 0);

      // 5: idle timeout
      do_reset();
      key(4'b0001);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         tick();
         cyc++;
         seen = TIMEOUT;
      end
      chk("t5_to_cycles", 32'(cyc), 100);
      chk("t5_to_empty", 32'(CART_EMPTY), 1);
      tick();
      chk("t5_to_pulse", 32'(TIMEOUT), 0);
      key(4'b0001);
      seen = 1'b0;
      for (int i = 0; i < 98; i++) begin
         tick();
         if (TIMEOUT) seen = 1'b1;
      end
      key(4'b0001);
      if (TIMEOUT) seen = 1'b1;
      chk("t5_no_early_to", 32'(seen), 0);
      chk("t5_qty0", 32'(QTY_VIEW[3:0]), 2);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         tick();
         cyc++;
         seen = TIMEOUT;
      end
      chk("t5_restart_cycles", 32'(cyc), 100);

      // 6: clear beats keys; reset mid-stream
      do_reset();
      KEY_En = 4'b1111;
      CMD_En = 4'b0010;
      tick();
      KEY_En = '0;
      CMD_En = '0;
      chk("t6_empty", 32'(CART_EMPTY), 1);
      chk("t6_view", 32'(QTY_VIEW), 0);
      chk("t6_err", 32'(ERR), 0);
      fill_std();
      cmd(4'b0100);
      chk("t6_busy", 32'(BUSY), 1);
      RST = 1'b1;
      tick();
      chk("t6_rst_valid", 32'(ITEM_VALID), 0);
      chk("t6_rst_view", 32'(QTY_VIEW), 0);
      chk("t6_rst_busy", 32'(BUSY), 0);
      RST = 1'b0;
      tick();
      chk("t6_rst_hold", 32'(ITEM_VALID), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
